// File: rtl/agu_pipe.sv
// Pipelined load/store address generation unit with a DEPTH-entry output FIFO.
// Define AGU_MISALIGN_DETECT_EN to enable per-entry misalignment detection.
module agu_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_base,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [2:0]       in_funct3,
  input  logic             in_is_store,
  input  logic [XLEN-1:0]  in_wdata,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_addr,
  output logic [XLEN-1:0]  out_addr_aligned,
  output logic [3:0]       out_rmask,
  output logic [3:0]       out_wmask,
  output logic [XLEN-1:0]  out_wdata,
  output logic [2:0]       out_funct3,
  output logic             out_is_store,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_misalign
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0]  addr;
    logic [3:0]       rmask;
    logic [3:0]       wmask;
    logic [XLEN-1:0]  wdata;
    logic [2:0]       funct3;
    logic             is_store;
    logic [TAG_W-1:0] tag;
  } entry_t;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [XLEN-1:0] w_addr;
  logic [3:0]      w_base_mask;
  logic [3:0]      w_mask;
  entry_t          w_entry;
  entry_t          w_head;
  logic            w_push;
  logic            w_pop;

  entry_t          r_mem [DEPTH];
  logic [PtrW-1:0] r_head;
  logic [PtrW-1:0] r_tail;
  logic [CntW-1:0] r_count;

  assign w_addr = in_base + in_imm;

  always_comb begin
    w_base_mask = 4'b0000;
    case (in_funct3)
      3'b000, 3'b100: w_base_mask = 4'b0001;
      3'b001, 3'b101: w_base_mask = 4'b0011;
      3'b010:         w_base_mask = 4'b1111;
      default:        w_base_mask = 4'b0000;
    endcase
  end

  // Shift in 4 bits so lanes past byte 3 fall off.
  assign w_mask = w_base_mask << w_addr[1:0];

  always_comb begin
    w_entry          = '0;
    w_entry.addr     = w_addr;
    w_entry.rmask    = in_is_store ? 4'b0000 : w_mask;
    w_entry.wmask    = in_is_store ? w_mask : 4'b0000;
    w_entry.wdata    = in_wdata << {w_addr[1:0], 3'b000};
    w_entry.funct3   = in_funct3;
    w_entry.is_store = in_is_store;
    w_entry.tag      = in_tag;
  end

  assign in_ready  = (r_count < CntW'(DEPTH)) || out_ready;
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready && !flush;
  assign w_pop     = out_valid && out_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= ptr_inc(r_tail);
      if (w_pop)  r_head <= ptr_inc(r_head);
      if (w_push && !w_pop)      r_count <= r_count + CntW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CntW'(1);
    end
  end

  // Payload needs no reset: outputs are gated to zero while empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= w_entry;
  end

  assign w_head = r_mem[r_head];

  always_comb begin
    out_addr         = '0;
    out_addr_aligned = '0;
    out_rmask        = '0;
    out_wmask        = '0;
    out_wdata        = '0;
    out_funct3       = '0;
    out_is_store     = 1'b0;
    out_tag          = '0;
    if (out_valid) begin
      out_addr         = w_head.addr;
      out_addr_aligned = {w_head.addr[XLEN-1:2], 2'b00};
      out_rmask        = w_head.rmask;
      out_wmask        = w_head.wmask;
      out_wdata        = w_head.wdata;
      out_funct3       = w_head.funct3;
      out_is_store     = w_head.is_store;
      out_tag          = w_head.tag;
    end
  end

`ifdef AGU_MISALIGN_DETECT_EN
  logic w_mis;
  logic r_mis [DEPTH];

  always_comb begin
    w_mis = 1'b0;
    case (in_funct3)
      3'b000, 3'b100: w_mis = 1'b0;
      3'b001, 3'b101: w_mis = w_addr[0];
      3'b010:         w_mis = |w_addr[1:0];
      default:        w_mis = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mis[r_tail] <= w_mis;
  end

  assign out_misalign = out_valid && r_mis[r_head];
`else
  assign out_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_agu_pipe.sv
// Scoreboard bench for agu_pipe: directed vectors push expectations, a monitor pops on retire.
module tb_agu_pipe;

`ifdef AGU_MISALIGN_DETECT_EN
  localparam bit MisEn = 1'b1;
`else
  localparam bit MisEn = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] aligned;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic        st;
    logic [4:0]  tag;
    logic        mis;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_base = '0;
  logic [31:0] in_imm = '0;
  logic [2:0]  in_funct3 = '0;
  logic        in_is_store = 1'b0;
  logic [31:0] in_wdata = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_addr;
  logic [31:0] out_addr_aligned;
  logic [3:0]  out_rmask;
  logic [3:0]  out_wmask;
  logic [31:0] out_wdata;
  logic [2:0]  out_funct3;
  logic        out_is_store;
  logic [4:0]  out_tag;
  logic        out_misalign;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  exp_t pend;

  agu_pipe #(.XLEN(32), .TAG_W(5), .DEPTH(2)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush            (flush),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_base          (in_base),
    .in_imm           (in_imm),
    .in_funct3        (in_funct3),
    .in_is_store      (in_is_store),
    .in_wdata         (in_wdata),
    .in_tag           (in_tag),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_addr         (out_addr),
    .out_addr_aligned (out_addr_aligned),
    .out_rmask        (out_rmask),
    .out_wmask        (out_wmask),
    .out_wdata        (out_wdata),
    .out_funct3       (out_funct3),
    .out_is_store     (out_is_store),
    .out_tag          (out_tag),
    .out_misalign     (out_misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: retire on out_valid && out_ready and compare with the oldest expectation.
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        a = '{out_addr, out_addr_aligned, out_rmask, out_wmask, out_wdata, out_funct3,
              out_is_store, out_tag, out_misalign};
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output: got tag %0d addr 0x%08h, expected none", out_tag,
                   out_addr);
        end else begin
          e = sb.pop_front();
          if (a !== e) begin
            n_fail++;
            $display("FAIL retire_tag%0d: got addr %h al %h rm %b wm %b wd %h f3 %b st %b tag %0d mis %b; expected addr %h al %h rm %b wm %b wd %h f3 %b st %b tag %0d mis %b",
                     e.tag, a.addr, a.aligned, a.rmask, a.wmask, a.wdata, a.f3, a.st, a.tag,
                     a.mis, e.addr, e.aligned, e.rmask, e.wmask, e.wdata, e.f3, e.st, e.tag,
                     e.mis);
          end
        end
      end
    end
  end

  task automatic drive(input logic [31:0] base, input logic [31:0] imm, input logic [2:0] f3,
                       input logic st, input logic [31:0] wd, input logic [4:0] tag,
                       input logic [31:0] ea, input logic [31:0] eal, input logic [3:0] erm,
                       input logic [3:0] ewm, input logic [31:0] ewd, input logic emis);
    in_base     = base;
    in_imm      = imm;
    in_funct3   = f3;
    in_is_store = st;
    in_wdata    = wd;
    in_tag      = tag;
    in_valid    = 1'b1;
    pend = '{ea, eal, erm, ewm, ewd, f3, st, tag, emis & MisEn};
  endtask

  task automatic wait_accept();
    bit done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready && !flush) begin
        sb.push_back(pend);
        done = 1'b1;
      end
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout_tag%0d: got no in_ready, expected accept", pend.tag);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic lw(input logic [31:0] base, input logic [4:0] tag);
    drive(base, 32'h0, 3'b010, 1'b0, 32'h0, tag, base, base, 4'b1111, 4'b0000, 32'h0, 1'b0);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    cycles(2);
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_out_addr", out_addr, 32'h0);
    check("idle_out_valid", {31'b0, out_valid}, 32'd0);
    cycles(1);

    // Directed vectors, back-to-back with out_ready high.
    out_ready = 1'b1;
    drive(32'h1000, 32'h4, 3'b010, 1'b0, 32'h12345678, 5'd1,
          32'h1004, 32'h1004, 4'b1111, 4'b0000, 32'h12345678, 1'b0);
    wait_accept();
    @(negedge clk);
    check("latency_out_valid", {31'b0, out_valid}, 32'd1);
    @(posedge clk);
    #1;
    drive(32'h2001, 32'h2, 3'b000, 1'b1, 32'h000000AB, 5'd2,
          32'h2003, 32'h2000, 4'b0000, 4'b1000, 32'hAB000000, 1'b0);
    wait_accept();
    drive(32'hFFFFFFFC, 32'h8, 3'b010, 1'b0, 32'h0, 5'd3,
          32'h4, 32'h4, 4'b1111, 4'b0000, 32'h0, 1'b0);
    wait_accept();
    drive(32'h100, 32'h2, 3'b001, 1'b1, 32'h1234CDEF, 5'd4,
          32'h102, 32'h100, 4'b0000, 4'b1100, 32'hCDEF0000, 1'b0);
    wait_accept();
    drive(32'h3000, 32'h1, 3'b001, 1'b0, 32'h0, 5'd5,
          32'h3001, 32'h3000, 4'b0110, 4'b0000, 32'h0, 1'b1);
    wait_accept();
    drive(32'h10, 32'hFFFFFFFF, 3'b100, 1'b0, 32'h0, 5'd6,
          32'hF, 32'hC, 4'b1000, 4'b0000, 32'h0, 1'b0);
    wait_accept();
    drive(32'h40, 32'h0, 3'b011, 1'b0, 32'h55, 5'd7,
          32'h40, 32'h40, 4'b0000, 4'b0000, 32'h55, 1'b1);
    wait_accept();
    drive(32'h21, 32'h0, 3'b010, 1'b1, 32'hAABBCCDD, 5'd8,
          32'h21, 32'h20, 4'b0000, 4'b1110, 32'hBBCCDD00, 1'b1);
    wait_accept();
    drive(32'hFFFFFFFE, 32'h2, 3'b010, 1'b0, 32'h0, 5'd9,
          32'h0, 32'h0, 4'b1111, 4'b0000, 32'h0, 1'b0);
    wait_accept();
    drive(32'h7, 32'h0, 3'b101, 1'b0, 32'h0, 5'd10,
          32'h7, 32'h4, 4'b1000, 4'b0000, 32'h0, 1'b1);
    wait_accept();
    cycles(3);
    check("drain_empty", {31'b0, out_valid}, 32'd0);

    // Backpressure: two entries fill the buffer, third waits until a pop frees a slot.
    out_ready = 1'b0;
    lw(32'h400, 5'd11);
    wait_accept();
    lw(32'h404, 5'd12);
    wait_accept();
    lw(32'h408, 5'd13);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("full_in_ready", {31'b0, in_ready}, 32'd0);
      check("stall_head_tag", {27'b0, out_tag}, 32'd11);
      check("stall_head_addr", out_addr, 32'h400);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_accept();
    cycles(3);
    check("bp_drained", {31'b0, out_valid}, 32'd0);

    // Flush with two buffered entries and an accepted same-cycle push.
    out_ready = 1'b0;
    lw(32'h500, 5'd20);
    wait_accept();
    lw(32'h504, 5'd21);
    wait_accept();
    lw(32'h508, 5'd22);
    flush = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("flush_cycle_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    check("flush_out_valid", {31'b0, out_valid}, 32'd0);
    check("flush_out_addr", out_addr, 32'h0);
    cycles(3);

    // Asynchronous reset mid-stream drops buffered entries.
    out_ready = 1'b0;
    lw(32'h600, 5'd24);
    wait_accept();
    lw(32'h604, 5'd25);
    wait_accept();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("async_reset_in_ready", {31'b0, in_ready}, 32'd1);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    lw(32'h700, 5'd26);
    wait_accept();
    cycles(4);
    check("final_scoreboard_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/agu_pipe.md
Name: agu_pipe

Overview:
- Pipelined, parametrised address generation unit for the load/store path.
- Sits between the reservation-station issue port and the load/store queue.
- Per accepted request: computes the effective address, the word-aligned address, the byte mask and the lane-shifted store data, and carries the ROB tag through.
- Valid/ready handshakes on both sides, a DEPTH-entry output buffer, and a synchronous flush for mispredict recovery.

Parameters:
- XLEN, 32, width of operands, address and data.
- TAG_W, 5, ROB tag width.
- DEPTH, 2, output buffer entries; legal values 1..8.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of all buffered entries and the input beat of this cycle.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept this cycle.
- in_base  in  XLEN  rs1 value.
- in_imm  in  XLEN  sign-extended immediate.
- in_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
- in_is_store  in  1  1 = store, 0 = load.
- in_wdata  in  XLEN  rs2 store data.
- in_tag  in  TAG_W  ROB index.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- out_addr  out  XLEN  effective address.
- out_addr_aligned  out  XLEN  out_addr with bits [1:0] cleared.
- out_rmask  out  4  load byte mask; 0 for stores.
- out_wmask  out  4  store byte mask; 0 for loads.
- out_wdata  out  XLEN  in_wdata shifted left by 8*addr[1:0].
- out_funct3  out  3  passthrough.
- out_is_store  out  1  passthrough.
- out_tag  out  TAG_W  passthrough.
- out_misalign  out  1  access misaligned (see Optional Feature).

Behaviour:
- Effective address:
  - addr = in_base + in_imm, unsigned modulo 2^XLEN.
  - Overflow wraps silently, e.g. 0xFFFFFFFC + 8 = 0x00000004.
- Base mask by size: B 4'b0001, H 4'b0011, W 4'b1111.
  - Mask = base mask << addr[1:0], truncated to 4 bits.
  - Routed to rmask when in_is_store=0, to wmask when 1; the other mask is 0.
- wdata = in_wdata << (8*addr[1:0]); bits shifted past XLEN are dropped.
- Undefined funct3 (011, 110, 111):
  - Both masks 0; entry still flows through.
  - out_misalign=1 when the feature is enabled.
- Buffer:
  - Circular FIFO of DEPTH entries; head/tail pointers wrap at DEPTH; count in 0..DEPTH.
  - Computation is combinational on input; the result is written into the buffer at the accepting edge.
- Handshakes:
  - Input accepted when in_valid && in_ready.
  - Output retired when out_valid && out_ready.
  - in_ready = (count < DEPTH) || out_ready. Full with a simultaneous pop still accepts.
  - out_valid = (count != 0). The head-entry fields are stable while out_valid && !out_ready.
- Latency:
  - 1 cycle: a request accepted at edge N appears on the outputs after edge N when the buffer was empty.
  - Throughput 1 per cycle with out_ready held high.
- Simultaneous push and pop: count is unchanged, both pointers advance.
- Flush:
  - At the next edge count=0 and pointers=0.
  - The same-cycle input beat is discarded even if in_valid && in_ready.
  - Flush has priority over push and pop.
- Reset (rst_n=0, asynchronous):
  - count=0, pointers=0, out_valid=0, in_ready=1.
  - Data outputs are 0 while the buffer is empty (fields of an empty head are driven to 0, not X).
  - Reset mid-stream drops all entries.

Optional Feature:
- Macro: AGU_MISALIGN_DETECT_EN.
- Enabled:
  - out_misalign=1 when H/HU has addr[0]=1, when W has addr[1:0]!=0, or on undefined funct3.
  - Masks are still produced but the consumer must trap on out_misalign.
  - The flag is stored per entry.
- Disabled:
  - out_misalign is constant 0; no storage for it.
  - Misaligned mask bits beyond bit 3 are truncated silently.

Test Plan:
- Reset then idle → out_valid=0, in_ready=1, out_addr=0.
- LW: base 0x1000, imm 0x4 → next cycle out_addr=0x1004, aligned 0x1004, rmask=4'b1111, wmask=0, out_misalign=0.
- SB: base 0x2001, imm 0x2, wdata 0x000000AB → out_addr=0x2003, wmask=4'b1000, out_wdata=0xAB000000, rmask=0.
- Backpressure with DEPTH=2:
  - Hold out_ready=0 and push three LW → in_ready drops after two; heads stay stable.
  - Raise out_ready with a third in_valid held → pop and push occur the same cycle; order preserved by tag 1, 2, 3.
- Flush with two buffered entries plus a same-cycle push → next cycle out_valid=0, count=0; the pushed entry never appears.
- With the macro enabled: LH at addr 0x3001 → out_misalign=1. LW with base 0xFFFFFFFE, imm 0x2 → out_addr=0x00000000, out_misalign=0.
